// File: rtl/irrigation_sequencer.sv
// Irrigation sequencer: synchronises the raw sensor and switch pins, then runs a
// registered Moore FSM that drives the sprinkler valve, drip valve, fill pump and
// fault alarm. Outputs are decoded from the next state, so they change on the
// same edge as the state register.
`timescale 1ns/1ps

module irrigation_sequencer #(
   parameter int MIN_RUN      = 8,
   parameter int FILL_TIMEOUT = 64,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [2:0] tank_lvl,
   input  logic [1:0] soil_moist,
   input  logic       alarm_clr,
   output logic       valve_sprinkler,
   output logic       valve_drip,
   output logic       pump_fill,
   output logic       alarm,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'b000,
      ST_IRRIGATE = 3'b001,
      ST_FILL     = 3'b010,
      ST_FAULT    = 3'b011
   } state_t;

   localparam int SYNC_W = 7;
   localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MIN_RUN - 1);
   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_TIMEOUT - 1);

   // Mode bit latched on IRRIGATE entry: 0 = sprinkler, 1 = drip.
   localparam logic MODE_SPRINKLER = 1'b0;
   localparam logic MODE_DRIP      = 1'b1;

   // ---------------------------------------------------------------------------
   // Input synchronisers: every asynchronous pin gets its own 2-flop chain.
   // ---------------------------------------------------------------------------
   logic [SYNC_W-1:0] raw_in;
   logic [SYNC_W-1:0] sync_out;

   assign raw_in = {alarm_clr, soil_moist, tank_lvl, en};

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_W; gi++) begin : g_sync
         logic s1_reg;
         logic s2_reg;

         // Two-stage metastability filter for one input bit.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s1_reg <= 1'b0;
               s2_reg <= 1'b0;
            end else begin
               s1_reg <= raw_in[gi];
               s2_reg <= s1_reg;
            end
         end

         assign sync_out[gi] = s2_reg;
      end
   endgenerate

   logic       en_s;
   logic [2:0] tank_s;
   logic [1:0] soil_s;
   logic       clr_s;

   assign en_s   = sync_out[0];
   assign tank_s = sync_out[3:1];
   assign soil_s = sync_out[5:4];
   assign clr_s  = sync_out[6];

   // ---------------------------------------------------------------------------
   // Sensor decode. Tank probes are thermometer coded; anything else means a
   // broken probe. Soil code 11 is likewise an invalid sensor reading.
   // ---------------------------------------------------------------------------
   logic tank_empty;
   logic tank_full;
   logic tank_bad;
   logic soil_bad;
   logic any_fault;

   assign tank_empty = (tank_s == 3'b000);
   assign tank_full  = (tank_s == 3'b111);
   assign tank_bad   = !(tank_empty || tank_full ||
                         (tank_s == 3'b001) || (tank_s == 3'b011));
   assign soil_bad   = (soil_s == 2'b11);
   assign any_fault  = tank_bad || soil_bad;

   // ---------------------------------------------------------------------------
   // State, counter and mode registers.
   // ---------------------------------------------------------------------------
   state_t           state_reg;
   state_t           state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             mode_reg;
   logic             mode_next;
   logic             valve_sprinkler_reg;
   logic             valve_drip_reg;
   logic             pump_fill_reg;
   logic             alarm_reg;

   // Next-state logic. Priority: sensor fault, then enable off, then empty tank,
   // then the per-state normal transition.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      mode_next  = mode_reg;

      case (state_reg)
         ST_IDLE: begin
            if (any_fault) begin
               state_next = ST_FAULT;
            end else if (!en_s) begin
               state_next = ST_IDLE;
            end else if (tank_empty) begin
               state_next = ST_FILL;
               cnt_next   = '0;
            end else if (soil_s == 2'b00) begin
               state_next = ST_IRRIGATE;
               mode_next  = MODE_SPRINKLER;
               cnt_next   = '0;
            end else if (soil_s == 2'b01) begin
               state_next = ST_IRRIGATE;
               mode_next  = MODE_DRIP;
               cnt_next   = '0;
            end
         end

         ST_IRRIGATE: begin
            if (any_fault) begin
               state_next = ST_FAULT;
            end else if (!en_s) begin
               state_next = ST_IDLE;
            end else if (tank_empty) begin
               // Refill takes precedence over the minimum run time.
               state_next = ST_FILL;
               cnt_next   = '0;
            end else if ((soil_s == 2'b10) && (cnt_reg == RUN_LAST)) begin
               state_next = ST_IDLE;
            end else if (cnt_reg != RUN_LAST) begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         ST_FILL: begin
            if (any_fault) begin
               state_next = ST_FAULT;
            end else if (!en_s) begin
               state_next = ST_IDLE;
            end else if (tank_full) begin
               state_next = ST_IDLE;
            end else if (cnt_reg == FILL_LAST) begin
               // Pump ran the full budget without reaching the top probe.
               state_next = ST_FAULT;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         ST_FAULT: begin
            // Only an acknowledge with healthy sensors releases the alarm.
            if (clr_s && !any_fault) begin
               state_next = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // FSM register: state, counter, mode and the actuator outputs decoded from
   // the next state so they move on the same edge as the state code.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg           <= ST_IDLE;
         cnt_reg             <= '0;
         mode_reg            <= MODE_SPRINKLER;
         valve_sprinkler_reg <= 1'b0;
         valve_drip_reg      <= 1'b0;
         pump_fill_reg       <= 1'b0;
         alarm_reg           <= 1'b0;
      end else begin
         state_reg           <= state_next;
         cnt_reg             <= cnt_next;
         mode_reg            <= mode_next;
         valve_sprinkler_reg <= (state_next == ST_IRRIGATE) && (mode_next == MODE_SPRINKLER);
         valve_drip_reg      <= (state_next == ST_IRRIGATE) && (mode_next == MODE_DRIP);
         pump_fill_reg       <= (state_next == ST_FILL);
         alarm_reg           <= (state_next == ST_FAULT);
      end
   end

   assign valve_sprinkler = valve_sprinkler_reg;
   assign valve_drip      = valve_drip_reg;
   assign pump_fill       = pump_fill_reg;
   assign alarm           = alarm_reg;
   assign state           = state_reg;

endmodule
